// File: rtl/maj_pkg.sv
//------------------------------------------------------------------------------
// Module   : maj_pkg
// Brief    : Shared constants and state type for the 7-vote majority datapath.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package maj_pkg;
   localparam int N_VOTES    = 7;
   localparam int CNT_W      = 3;
   localparam int MAJ_THRESH = 4;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      RESULT  = 1'b1
   } state_t;
endpackage

`default_nettype wire

// File: rtl/maj7.sv
//------------------------------------------------------------------------------
// Module   : maj7
// Brief    : Combinational 7-input majority gate.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module maj7
   import maj_pkg::*;
(
   input  logic v0,
   input  logic v1,
   input  logic v2,
   input  logic v3,
   input  logic v4,
   input  logic v5,
   input  logic v6,
   output logic majority
);

   logic [CNT_W-1:0] w_sum;

   assign w_sum = {2'b00, v0} + {2'b00, v1} + {2'b00, v2} + {2'b00, v3}
                + {2'b00, v4} + {2'b00, v5} + {2'b00, v6};

   assign majority = (w_sum >= CNT_W'(MAJ_THRESH));

endmodule

`default_nettype wire

// File: rtl/maj7_serial_voter.sv
//------------------------------------------------------------------------------
// Module   : maj7_serial_voter
// Brief    : Collects seven serial votes and presents majority and ones-count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module maj7_serial_voter
   import maj_pkg::*;
#(
   parameter int N_VOTES = maj_pkg::N_VOTES,
   parameter int CNT_W   = maj_pkg::CNT_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_vote,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_majority,
   output logic [CNT_W-1:0] out_ones,
   output logic             busy
);

   function automatic logic [CNT_W-1:0] popcount(input logic [N_VOTES-1:0] w);
      logic [CNT_W-1:0] s;
      s = '0;
      for (int i = 0; i < N_VOTES; i++) begin
         s = s + CNT_W'(w[i]);
      end
      return s;
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [N_VOTES-1:0] r_vote;
   logic [N_VOTES-1:0] w_next_word;
   logic               w_accept;
   logic               w_last;
   logic               w_handshake;
   logic               w_majority;

   assign in_ready    = (r_state == COLLECT) && !rst;
   assign out_valid   = (r_state == RESULT);
   assign busy        = (r_state == RESULT) || (r_cnt != '0);
   assign w_accept    = in_valid && in_ready;
   assign w_last      = (r_cnt == CNT_W'(N_VOTES - 1));
   assign w_handshake = out_valid && out_ready;

   // Vote word as it will look after this cycle's accept, so the 7th vote counts.
   always_comb begin
      w_next_word = r_vote;
      for (int i = 0; i < N_VOTES; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_next_word[i] = in_vote;
         end
      end
   end

   maj7 u_maj7 (
      .v0       (w_next_word[0]),
      .v1       (w_next_word[1]),
      .v2       (w_next_word[2]),
      .v3       (w_next_word[3]),
      .v4       (w_next_word[4]),
      .v5       (w_next_word[5]),
      .v6       (w_next_word[6]),
      .majority (w_majority)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = COLLECT;
      end else begin
         case (r_state)
            COLLECT: if (w_accept && w_last) w_state_nxt = RESULT;
            RESULT:  if (out_ready)          w_state_nxt = COLLECT;
            default:                         w_state_nxt = COLLECT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_vote       <= '0;
         out_majority <= 1'b0;
         out_ones     <= '0;
      end else if (flush) begin
         r_cnt        <= '0;
         r_vote       <= '0;
         out_majority <= 1'b0;
         out_ones     <= '0;
      end else begin
         if (w_accept) begin
            r_vote <= w_next_word;
            if (w_last) begin
               r_cnt        <= '0;
               out_majority <= w_majority;
               out_ones     <= popcount(w_next_word);
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
         if (w_handshake) begin
            r_vote <= '0;
         end
      end
   end

   a_cnt_range: assert property (@(posedge clk) disable iff (rst) r_cnt < CNT_W'(N_VOTES));

endmodule

`default_nettype wire

// File: tb/tb_maj7_serial_voter.sv
//------------------------------------------------------------------------------
// Module   : tb_maj7_serial_voter
// Brief    : Randomized self-checking bench for maj7_serial_voter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_maj7_serial_voter;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_vote;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic       out_majority;
   logic [2:0] out_ones;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   maj7_serial_voter dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_vote      (in_vote),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_majority (out_majority),
      .out_ones     (out_ones),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents v0..v6 in order, with optional random idle cycles before each vote.
   task automatic feed_window(input logic [6:0] w, input int max_gap);
      for (int i = 0; i < 7; i++) begin
         int g;
         g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         in_valid = 1'b0;
         repeat (g) tick();
         in_valid = 1'b1;
         in_vote  = w[i];
         tick();
      end
      in_valid = 1'b0;
      in_vote  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_vote = 1'b0; flush = 1'b0; out_ready = 1'b0;
      #12;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
      n_vec++; if (out_ones !== 3'd0) begin n_err++; $display("FAIL rst_out_ones got %0d want 0", out_ones); end
      n_vec++; if (out_majority !== 1'b0) begin n_err++; $display("FAIL rst_out_majority got %b want 0", out_majority); end
      #5 rst = 1'b0;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      tick();
   endtask

   task automatic test_three_ones();
      out_ready = 1'b1;
      feed_window(7'b0000111, 0);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t3_valid got %b want 1", out_valid); end
      n_vec++; if (out_majority !== 1'b0) begin n_err++; $display("FAIL t3_majority got %b want 0", out_majority); end
      n_vec++; if (out_ones !== 3'd3) begin n_err++; $display("FAIL t3_ones got %0d want 3", out_ones); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t3_in_ready got %b want 0", in_ready); end
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t3_valid_after got %b want 0", out_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t3_busy_after got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      feed_window(7'b1010101, 0);
      for (int c = 0; c < 5; c++) begin
         n_vec++; if (out_valid !== 1'b1 || out_majority !== 1'b1 || out_ones !== 3'd4)
            begin n_err++; $display("FAIL bp_hold cyc %0d got v=%b m=%b o=%0d want v=1 m=1 o=4", c, out_valid, out_majority, out_ones); end
         n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc %0d got %b want 0", c, in_ready); end
         tick();
      end
      out_ready = 1'b1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_hs got %b want 1", out_valid); end
      tick();
      out_ready = 1'b0;
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin n_err++; $display("FAIL bp_after_hs got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
   endtask

   task automatic test_exhaustive();
      out_ready = 1'b1;
      for (int p = 0; p < 128; p++) begin
         logic [6:0] w;
         int         ones;
         w    = 7'(p);
         ones = $countones(w);
         feed_window(w, 0);
         n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ex_valid pat %0d got %b want 1", p, out_valid); end
         n_vec++; if (out_ones !== 3'(ones)) begin n_err++; $display("FAIL ex_ones pat %0d got %0d want %0d", p, out_ones, ones); end
         n_vec++; if (out_majority !== (ones >= 4)) begin n_err++; $display("FAIL ex_majority pat %0d got %b want %b", p, out_majority, ones >= 4); end
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_flush_partial();
      feed_window(7'b0000000, 0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin in_vote = 1'b1; tick(); end
      flush = 1'b1; in_vote = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fp_busy got %b want 0", busy); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fp_in_ready got %b want 1", in_ready); end
      feed_window(7'b0000000, 0);
      n_vec++; if (out_valid !== 1'b1 || out_ones !== 3'd0 || out_majority !== 1'b0)
         begin n_err++; $display("FAIL fp_residue got v=%b o=%0d m=%b want v=1 o=0 m=0", out_valid, out_ones, out_majority); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_flush_result();
      feed_window(7'b1111111, 0);
      n_vec++; if (out_valid !== 1'b1 || out_ones !== 3'd7)
         begin n_err++; $display("FAIL fr_pre got v=%b o=%0d want v=1 o=7", out_valid, out_ones); end
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; out_ready = 1'b0;
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
         begin n_err++; $display("FAIL fr_drop got v=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
      n_vec++; if (out_ones !== 3'd0 || out_majority !== 1'b0)
         begin n_err++; $display("FAIL fr_clear got o=%0d m=%b want 0 0", out_ones, out_majority); end
   endtask

   task automatic test_async_reset();
      logic [6:0] w;
      int         ones;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin in_vote = 1'($urandom); tick(); end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0)
         begin n_err++; $display("FAIL ar_mid_window got busy=%b v=%b want 0 0", busy, out_valid); end
      #1 rst = 1'b0;
      tick();
      feed_window(7'b1110111, 0);
      #2 rst = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0 || out_ones !== 3'd0 || out_majority !== 1'b0)
         begin n_err++; $display("FAIL ar_mid_result got v=%b o=%0d m=%b want 0 0 0", out_valid, out_ones, out_majority); end
      #1 rst = 1'b0;
      tick();
      w    = 7'($urandom);
      ones = $countones(w);
      feed_window(w, 2);
      n_vec++; if (out_valid !== 1'b1 || out_ones !== 3'(ones) || out_majority !== (ones >= 4))
         begin n_err++; $display("FAIL ar_next_window got v=%b o=%0d m=%b want v=1 o=%0d m=%b", out_valid, out_ones, out_majority, ones, ones >= 4); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_random_gaps();
      for (int k = 0; k < 24; k++) begin
         logic [6:0] w;
         int         ones;
         int         d;
         w    = 7'($urandom);
         ones = $countones(w);
         d    = int'($urandom_range(3, 0));
         out_ready = 1'b0;
         feed_window(w, 3);
         for (int c = 0; c <= d; c++) begin
            n_vec++; if (out_valid !== 1'b1 || out_ones !== 3'(ones) || out_majority !== (ones >= 4) || in_ready !== 1'b0)
               begin n_err++; $display("FAIL rg_result win %0d cyc %0d got v=%b o=%0d m=%b rdy=%b want v=1 o=%0d m=%b rdy=0",
                                       k, c, out_valid, out_ones, out_majority, in_ready, ones, ones >= 4); end
            if (c == d) out_ready = 1'b1;
            tick();
         end
         out_ready = 1'b0;
         n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL rg_release win %0d got v=%b rdy=%b want 0 1", k, out_valid, in_ready); end
      end
   endtask

   initial begin
      test_reset();
      test_three_ones();
      test_backpressure();
      test_exhaustive();
      test_flush_partial();
      test_flush_result();
      test_async_reset();
      test_random_gaps();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
